// File: rtl/io_bus_interconnect_pkg.sv
// Shared definitions for the split read/write IO bus interconnect:
// FSM encoding, default bus widths, default device map and timeout.
package io_bus_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned IO_ADDR_W = 32;
  localparam int unsigned IO_DATA_W = 32;
  localparam int unsigned IO_CTRL_W = 3;

  localparam logic [31:0] SW_BASE   = 32'hFFFF_F000;
  localparam logic [31:0] LED_BASE  = 32'hFFFF_F100;
  localparam logic [31:0] SEG_BASE  = 32'hFFFF_F200;
  localparam logic [31:0] WIN_MASK  = 32'hFFFF_FF00;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/io_addr_decoder.sv
// Combinational address window decode: masked compare per channel, lowest
// matching index wins.
module io_addr_decoder
  import io_bus_interconnect_pkg::*;
#(
  parameter int unsigned ADDR_W  = IO_ADDR_W,
  parameter int unsigned NUM_DEV = 4,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = '0,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = '1
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit_any,
  output logic [NUM_DEV-1:0] sel
);

  always_comb begin
    hit_any = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!hit_any &&
          ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) ==
           (DEV_BASE[i*ADDR_W +: ADDR_W] & DEV_MASK[i*ADDR_W +: ADDR_W]))) begin
        sel[i]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_interconnect.sv
// Core-to-device IO interconnect: decodes each access onto one device channel,
// waits on that channel's ready, and terminates unmapped or hung accesses with an error.
module io_bus_interconnect
  import io_bus_interconnect_pkg::*;
#(
  parameter int unsigned ADDR_W  = IO_ADDR_W,
  parameter int unsigned DATA_W  = IO_DATA_W,
  parameter int unsigned CTRL_W  = IO_CTRL_W,
  parameter int unsigned NUM_DEV = 4,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = '0,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = {NUM_DEV{{(ADDR_W-8){1'b1}}, 8'h00}},
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_req,
  input  logic                      m_we,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [CTRL_W-1:0]         m_ctrl,
  input  logic [DATA_W-1:0]         m_wd,
  output logic [DATA_W-1:0]         m_rd,
  output logic                      m_ready,
  output logic                      m_err,
  output logic [NUM_DEV-1:0]        d_sel,
  output logic                      d_we,
  output logic [ADDR_W-1:0]         d_addr,
  output logic [CTRL_W-1:0]         d_ctrl,
  output logic [DATA_W-1:0]         d_wd,
  input  logic [NUM_DEV*DATA_W-1:0] d_rd,
  input  logic [NUM_DEV-1:0]        d_ready
);

  state_t              state, state_nxt;
  logic                dec_hit;
  logic [NUM_DEV-1:0]  dec_sel;
  logic [NUM_DEV-1:0]  sel_q;
  logic                we_q;
  logic [7:0]          cnt;
  logic [DATA_W-1:0]   rd_q;
  logic                err_q;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rd;
  logic                timed_out;

  io_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_DEV  (NUM_DEV),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_dec (
    .addr    (m_addr),
    .hit_any (dec_hit),
    .sel     (dec_sel)
  );

  // Only the selected channel's ready and read data are ever observed.
  always_comb begin
    sel_ready = |(d_ready & sel_q);
    timed_out = (cnt == 8'(TIMEOUT - 1));
    sel_rd    = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i]) sel_rd = sel_rd | d_rd[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_req) state_nxt = dec_hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      we_q   <= 1'b0;
      d_addr <= '0;
      d_ctrl <= '0;
      d_wd   <= '0;
      cnt    <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req) begin
            we_q   <= m_we;
            d_addr <= m_addr;
            d_ctrl <= m_ctrl;
            d_wd   <= m_wd;
            sel_q  <= dec_sel;
            cnt    <= '0;
            rd_q   <= '0;
            err_q  <= !dec_hit;
          end
        end
        ACCESS: begin
          // Ready is tested before the timeout so a late ready still succeeds.
          if (sel_ready) begin
            rd_q  <= we_q ? '0 : sel_rd;
            err_q <= 1'b0;
            sel_q <= '0;
          end else if (timed_out) begin
            rd_q  <= '0;
            err_q <= 1'b1;
            sel_q <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_ready = (state == RESP);
    m_err   = m_ready & err_q;
    m_rd    = m_ready ? rd_q : '0;
    d_sel   = (state == ACCESS) ? sel_q : '0;
    d_we    = (state == ACCESS) & we_q;
  end

endmodule

// File: tb/tb_io_bus_interconnect.sv
// Randomized scoreboard bench for io_bus_interconnect with a transaction-level
// reference model of decode, wait states, timeout and reset abort.
module tb_io_bus_interconnect;

  localparam int TMO = 16;
  localparam logic [127:0] BASES = {32'h0000_8000, 32'hFFFF_F100, 32'hFFFF_F000, 32'h0000_8000};
  localparam logic [127:0] MASKS = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m_req = 1'b0, m_we = 1'b0;
  logic [31:0]  m_addr = '0, m_wd = '0;
  logic [2:0]   m_ctrl = '0;
  logic [31:0]  m_rd;
  logic         m_ready, m_err;
  logic [3:0]   d_sel;
  logic         d_we;
  logic [31:0]  d_addr, d_wd;
  logic [2:0]   d_ctrl;
  logic [127:0] d_rd = '0;
  logic [3:0]   d_ready = '0;

  io_bus_interconnect #(
    .ADDR_W(32), .DATA_W(32), .CTRL_W(3), .NUM_DEV(4),
    .DEV_BASE(BASES), .DEV_MASK(MASKS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_ctrl(m_ctrl), .m_wd(m_wd), .m_rd(m_rd), .m_ready(m_ready), .m_err(m_err),
    .d_sel(d_sel), .d_we(d_we), .d_addr(d_addr), .d_ctrl(d_ctrl), .d_wd(d_wd),
    .d_rd(d_rd), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference device map, index 0 first.
  logic [31:0] mbase [4] = '{32'h0000_8000, 32'hFFFF_F000, 32'hFFFF_F100, 32'h0000_8000};
  logic [31:0] mmask [4] = '{32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};

  typedef struct { int cyc; logic err; logic [31:0] rd; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [2:0] ctrl; logic [31:0] wd; logic [3:0] sel; } dexp_t;

  rsp_t  rq [$];
  dexp_t dexp [int];
  bit    zero_cyc [int];

  int n_tests = 0;
  int n_fail  = 0;

  bit          fix_rd = 1'b0;
  logic [31:0] fix_val = '0;
  bit          noise_ones = 1'b0;
  logic [31:0] rdv [4];

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mmask[i]) == (mbase[i] & mmask[i])) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against expectations issued by the stimulus.
  always @(negedge clk) begin
    if (cyc > 0) begin
      dexp_t e;
      rsp_t  r;
      if (zero_cyc.exists(cyc))
        chk("reset_zero", 64'(|{m_rd, m_ready, m_err, d_sel, d_we, d_addr, d_ctrl, d_wd}), 64'd0);
      if (dexp.exists(cyc)) begin
        e = dexp[cyc];
        chk("d_sel", 64'(d_sel), 64'(e.sel));
        chk("d_we", 64'(d_we), 64'(e.we));
        chk("d_addr", 64'(d_addr), 64'(e.addr));
        chk("d_ctrl", 64'(d_ctrl), 64'(e.ctrl));
        chk("d_wd", 64'(d_wd), 64'(e.wd));
      end else begin
        chk("d_sel_idle", 64'({d_sel, d_we}), 64'd0);
      end
      if (m_ready) begin
        if (rq.size() == 0) begin
          chk("m_ready_spurious", 64'(m_ready), 64'd0);
        end else begin
          r = rq.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
          chk("m_err", 64'(m_err), 64'(r.err));
          chk("m_rd", 64'(m_rd), 64'(r.rd));
        end
      end else begin
        chk("quiet_rd_err", 64'({m_rd, m_err}), 64'd0);
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          chk("m_ready_missing", 64'(m_ready), 64'd1);
          void'(rq.pop_front());
        end
      end
    end
  end

  task automatic drive_noise(input int dev, input int k, input int wt);
    logic [3:0] dr;
    for (int i = 0; i < 4; i++) rdv[i] = fix_rd ? fix_val : $urandom;
    d_rd = {rdv[3], rdv[2], rdv[1], rdv[0]};
    dr = noise_ones ? 4'hF : 4'($urandom);
    if (dev >= 0) dr[dev] = (k == wt);
    d_ready = dr;
  endtask

  task automatic garbage_req();
    m_req  = 1'($urandom);
    m_we   = 1'($urandom);
    m_addr = $urandom;
    m_ctrl = 3'($urandom);
    m_wd   = $urandom;
  endtask

  // Issue one access in the current (IDLE) cycle; returns in the next IDLE cycle.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int wt, input int rst_at);
    int    dev;
    rsp_t  r;
    dexp_t e;
    logic [2:0] ctrl;
    ctrl = 3'($urandom);
    dev  = ref_decode(addr);
    m_req = 1'b1; m_we = we; m_addr = addr; m_ctrl = ctrl; m_wd = wd;
    drive_noise(-1, 0, 0);
    @(posedge clk); #1;
    if (dev < 0) begin
      r.cyc = cyc; r.err = 1'b1; r.rd = '0;
      rq.push_back(r);
      garbage_req(); drive_noise(-1, 0, 0);
      @(posedge clk); #1;
      m_req = 1'b0;
      return;
    end
    for (int k = 0; k < TMO; k++) begin
      e.we = we; e.addr = addr; e.ctrl = ctrl; e.wd = wd; e.sel = 4'(1 << dev);
      dexp[cyc] = e;
      garbage_req();
      drive_noise(dev, k, wt);
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        zero_cyc[cyc] = 1'b1;
        rst = 1'b0; m_req = 1'b0;
        return;
      end
      if (k == wt) begin
        r.cyc = cyc + 1; r.err = 1'b0; r.rd = we ? 32'h0 : rdv[dev];
        rq.push_back(r);
        @(posedge clk); #1;
        break;
      end
      if (k == TMO - 1) begin
        r.cyc = cyc + 1; r.err = 1'b1; r.rd = '0;
        rq.push_back(r);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    garbage_req(); drive_noise(-1, 0, 0);
    @(posedge clk); #1;
    m_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int sel_kind, wsel, wt, rst_at;
    logic [31:0] a;
    rst = 1'b1;
    zero_cyc[1] = 1'b1; zero_cyc[2] = 1'b1; zero_cyc[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    fix_rd = 1'b1; fix_val = 32'hA5A5_A5A5;
    do_access(1'b0, 32'hFFFF_F004, 32'h0, 0, -1);
    fix_rd = 1'b0;
    do_access(1'b1, 32'hFFFF_F108, 32'h1234_5678, 3, -1);
    do_access(1'b0, 32'h0000_1000, 32'h0, 0, -1);
    do_access(1'b0, 32'hFFFF_F010, 32'h0, 1000, -1);
    do_access(1'b0, 32'hFFFF_F020, 32'h0, TMO - 1, -1);
    noise_ones = 1'b1;
    do_access(1'b0, 32'h0000_8010, 32'h0, 2, -1);
    noise_ones = 1'b0;
    do_access(1'b0, 32'hFFFF_F030, 32'h0, 100, 1);
    do_access(1'b0, 32'hFFFF_F040, 32'h0, 0, -1);

    for (int n = 0; n < 150; n++) begin
      sel_kind = $urandom_range(0, 5);
      case (sel_kind)
        0: a = 32'hFFFF_F000 | 32'($urandom_range(0, 255));
        1: a = 32'hFFFF_F100 | 32'($urandom_range(0, 255));
        2: a = 32'h0000_8000 | 32'($urandom_range(1, 15) << 8) | 32'($urandom_range(0, 255));
        3: a = 32'h0000_8000 | 32'($urandom_range(0, 255));
        4: a = $urandom;
        default: a = 32'h0000_1000 | 32'($urandom_range(0, 255));
      endcase
      wsel = $urandom_range(0, 9);
      case (wsel)
        6: wt = TMO - 1;
        7: wt = TMO;
        8: wt = 40;
        9: wt = 0;
        default: wt = wsel;
      endcase
      rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
      noise_ones = ($urandom_range(0, 3) == 0);
      do_access(1'($urandom), a, $urandom, wt, rst_at);
      repeat ($urandom_range(0, 2)) begin
        m_req = 1'b0; drive_noise(-1, 0, 0);
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_interconnect.md
Name: io_bus_interconnect

Overview:
- Parametrised successor to the single shared tri-state IO bus between the mini_rv core and its devices.
- Replaces the shared tri-state data line with split read and write buses.
- Decodes each core access onto one of NUM_DEV device channels by address window, supports device wait states through a per-device ready signal, and terminates unmapped or hung accesses with an error.
- Sits between mini_rv's memory port and the device controllers: switch, LED, seven-segment and future devices.

Parameters:
- ADDR_W, 32, address width (matches IO bus address width).
- DATA_W, 32, data width (matches IO bus data width).
- CTRL_W, 3, access-control width (size/sign code, passed through unchanged).
- NUM_DEV, 4, number of device channels (1..16).
- DEV_BASE, {NUM_DEV{32'h0}}, packed per-device base addresses; channel i is at bits [i*ADDR_W +: ADDR_W].
- DEV_MASK, {NUM_DEV{32'hFFFFFF00}}, packed per-device compare masks.
- TIMEOUT, 16, maximum number of cycles spent in ACCESS before an error completion (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m_req  in  1  core access request.
- m_we  in  1  write when 1, read when 0.
- m_addr  in  ADDR_W  access address.
- m_ctrl  in  CTRL_W  access control code.
- m_wd  in  DATA_W  write data.
- m_rd  out  DATA_W  read data, valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag, qualified by m_ready.
- d_sel  out  NUM_DEV  one-hot device select.
- d_we  out  1  registered write enable.
- d_addr  out  ADDR_W  registered address.
- d_ctrl  out  CTRL_W  registered control code.
- d_wd  out  DATA_W  registered write data.
- d_rd  in  NUM_DEV*DATA_W  packed per-device read data.
- d_ready  in  NUM_DEV  per-device completion.

Behaviour:
- Reset:
  - Reset is synchronous, active-high on rst, sampled at the rising edge of clk.
  - While rst=1, all outputs are 0 and the state is IDLE.
  - Reset mid-access aborts it: d_sel drops on the next edge, and m_ready is never asserted for the aborted access.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - m_req=1 latches m_we, m_addr, m_ctrl and m_wd into d_* and evaluates the decode.
  - Decode: hit[i] = ((m_addr & DEV_MASK[i]) == (DEV_BASE[i] & DEV_MASK[i])).
  - Multiple hits: the lowest index wins.
  - At least one hit: go to ACCESS with d_sel = onehot(winner) and the timeout counter cleared.
  - No hit: go to RESP with err=1, rd=0.
- ACCESS:
  - d_sel, d_we, d_addr, d_ctrl and d_wd are held stable.
  - Only d_ready of the selected channel is observed; all other d_ready bits are ignored.
  - Selected d_ready=1: on reads, capture that channel's d_rd slice; on writes, capture rd=0. Then go to RESP with err=0 and d_sel=0.
  - Counter reaches TIMEOUT-1 without ready: go to RESP with err=1, rd=0, d_sel=0.
  - Ready arriving in the same cycle as the timeout wins: err=0.
- RESP:
  - m_ready=1 and m_err/m_rd present for exactly one cycle, then return to IDLE.
  - m_req is ignored in RESP and sampled again in IDLE.
- Latency:
  - Zero-wait device (d_ready=1 in the first ACCESS cycle): m_ready asserts 2 cycles after the request is accepted.
  - Each wait cycle adds 1.
  - Unmapped access: m_ready asserts 1 cycle after acceptance.
- Throughput: back-to-back accesses need at least 1 IDLE cycle between them, so at most one access per 3 cycles.
- Outside RESP: m_rd=0, m_err=0, m_ready=0.
- Outside ACCESS: d_sel=0.
- d_we is gated: it is 1 only while in ACCESS and the latched access is a write. Devices must still qualify on d_sel.

Decomposition:
- Shared package/header: the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), default IO bus widths, default device map constants (switch, LED, seven-segment base addresses), and the TIMEOUT default.
- One natural sub-module, io_addr_decoder: purely combinational masked compare plus lowest-index priority encoder, with outputs hit_any and a one-hot select.

Test Plan:
- Zero-wait read: NUM_DEV=4, DEV_BASE[1]=32'hFFFFF000, m_addr=32'hFFFFF004, d_rd[1]=32'hA5A5A5A5, d_ready[1] tied to 1 -> d_sel=4'b0010 in cycle 1; m_ready=1, m_rd=32'hA5A5A5A5, m_err=0 in cycle 2.
- Wait-state write: write 32'h12345678 to device 2, d_ready[2] raised after 3 cycles -> d_wd/d_addr stable for those 3 cycles; m_ready after 5 cycles with m_rd=0, m_err=0.
- Unmapped address: m_addr=32'h00001000 matches no window -> d_sel stays 0; m_ready=1, m_err=1, m_rd=0 one cycle after acceptance.
- Timeout: selected device never readies, TIMEOUT=16 -> d_sel deasserts after 16 ACCESS cycles; m_ready=1, m_err=1 in the next cycle.
- Overlap and priority: windows 0 and 3 both match, d_ready[0]=0, d_ready[3]=1 -> d_sel=4'b0001; the access waits on device 0 and ignores d_ready[3].
- Reset mid-access: assert rst in the 2nd wait cycle -> next cycle all outputs 0 and state IDLE; no m_ready pulse; a new request afterwards completes normally.
